fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core: holds the PC, computes next-PC, and drives the instruction-memory address.
- Registers the fetched word into the IF/ID pipeline register.
- Sits directly upstream of the next-PC select mux: its PC+4 output and the EX-stage redirect target are the mux inputs, and it consumes the selected result.
- Supports stall, flush/redirect and a halt state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush or bubble.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit hold; freezes PC and IF/ID.
- redirect  input  1  taken branch/jump from EX; flush IF/ID and load target.
- redirect_target  input  32  new PC when redirect=1.
- halt_req  input  1  enter HALTED (ebreak/ecall retire).
- imem_addr  output  32  instruction-memory address (= pc).
- imem_rdata  input  32  instruction word, combinational read of imem_addr.
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_pc_plus4  output  32  if_id_pc+4.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- halted  output  1  1 while in HALTED.
- fetch_count  output  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC; if_id_pc=0; if_id_pc_plus4=0; if_id_instr=NOP_INSTR; if_id_valid=0; fetch_count=0; halted=0; state=BOOT.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: lasts exactly one cycle after rst deasserts; PC held; IF/ID loads bubble; then RUN. Guarantees a clean first fetch at RESET_PC.
  - RUN: per rising edge, priority halt_req > redirect > stall > normal.
    - halt_req=1: pc held; IF/ID bubble; -> HALTED.
    - redirect=1: pc<=redirect_target; IF/ID bubble (valid=0, instr=NOP_INSTR). Redirect overrides a simultaneous stall.
    - stall=1: pc and all IF/ID fields hold; fetch_count holds.
    - Normal: pc<=pc+4, mod 2^32 (0xFFFF_FFFC wraps to 0). IF/ID loads pc, pc+4, imem_rdata; valid=1; fetch_count<=fetch_count+1, wrapping at 2^32.
  - HALTED: pc frozen; IF/ID bubble; stall/redirect/halt_req ignored; halted=1. Exit only via rst.
- Timing:
  - imem_addr is the combinational copy of pc, with zero latency.
  - Fetch-to-IF/ID latency is 1 cycle.
  - Redirect costs exactly one bubble: the target instruction appears in IF/ID 2 edges after redirect is sampled.
- if_id_pc_plus4 is registered, not recomputed from if_id_pc.
- Reset asserted mid-operation returns all state to the reset values immediately, without waiting for a clock edge.
- redirect_target[1:0] is not altered; the PC is loaded as given.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- When defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_target[1:0]!=0 in RUN sets fetch_misalign=1 (sticky) and enters HALTED instead of loading the target. pc keeps its old value.
- When undefined: no extra port; any target is loaded unchanged.

Decomposition:
- Shared package fetch_pkg:
  - state enum (BOOT=2'd0, RUN=2'd1, HALTED=2'd2)
  - NOP_INSTR constant
  - XLEN=32
  - IF/ID record typedef (pc, pc_plus4, instr, valid), reusable by decode.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/bubble controls.
- The PC register and FSM stay in fetch_stage.

Test Plan:
- Reset release, RESET_PC=0, imem returns addr|0xA000_0000, no stall. Required: imem_addr sequence 0,0(BOOT),4,8. IF/ID valid from the 2nd edge after BOOT with pc=0, instr=0xA000_0000. fetch_count=3 after 3 RUN edges.
- stall=1 for 3 cycles at pc=0x10. Required: imem_addr stays 0x10, IF/ID unchanged, fetch_count unchanged. Resumes at 0x14 afterwards.
- redirect=1 with stall=1, target=0x100. Required: next pc=0x100, IF/ID valid=0 and instr=0x0000_0013. Next edge: IF/ID pc=0x100, valid=1.
- pc=0xFFFF_FFFC in normal fetch. Required: next pc=0x0000_0000. if_id_pc_plus4=0x0000_0000 for that instruction.
- halt_req=1 together with redirect=1, target 0x200. Required: halted=1, pc unchanged, IF/ID bubble. A later redirect is ignored. Async rst mid-cycle clears halted and loads RESET_PC.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102. Required: fetch_misalign=1, halted=1, pc unchanged. Without the macro: pc=0x102.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side types: state encoding, bubble instruction and the IF/ID record.
// The IF/ID record is meant to be reused unchanged by the decode stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// Bubble takes priority over load; with neither asserted the contents hold.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  if_id_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (bubble_i) begin
      entry_d.pc       = '0;
      entry_d.pc_plus4 = '0;
      entry_d.instr    = BUBBLE_INSTR;
      entry_d.valid    = 1'b0;
    end else if (load_i) begin
      entry_d.pc       = pc_i;
      entry_d.pc_plus4 = pc_plus4_i;
      entry_d.instr    = instr_i;
      entry_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q.pc       <= '0;
      entry_q.pc_plus4 <= '0;
      entry_q.instr    <= BUBBLE_INSTR;
      entry_q.valid    <= 1'b0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign pc_o       = entry_q.pc;
  assign pc_plus4_o = entry_q.pc_plus4;
  assign instr_o    = entry_q.instr;
  assign valid_o    = entry_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, BOOT/RUN/HALTED FSM and IF/ID register.
// Optional FETCH_MISALIGN_CHK_EN halts on a redirect to a non word-aligned target.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        fetch_misalign,
`endif
  output logic [31:0] fetch_count
);

  localparam logic [1:0] ST_BOOT   = BOOT;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_HALTED = HALTED;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        load, bubble;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_q, misalign_d;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  // Priority in RUN: halt_req > redirect > stall > normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load    = 1'b0;
    bubble  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_BOOT: begin
        bubble  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          bubble  = 1'b1;
          state_d = ST_HALTED;
        end else if (redirect) begin
          bubble = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
          if (redirect_target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ST_HALTED;
          end else begin
            pc_d = redirect_target;
          end
`else
          pc_d = redirect_target;
`endif
        end else if (!stall) begin
          pc_d    = pc_plus4;
          load    = 1'b1;
          count_d = count_q + 32'd1;
        end
      end
      default: begin
        bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign fetch_misalign = misalign_q;
`endif

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .bubble_i  (bubble),
    .pc_i      (pc_q),
    .pc_plus4_i(pc_plus4),
    .instr_i   (imem_rdata),
    .pc_o      (if_id_pc),
    .pc_plus4_o(if_id_pc_plus4),
    .instr_o   (if_id_instr),
    .valid_o   (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = count_q;

endmodule
